instruction_queue: RTL and testbench



---
 rtl/instruction_queue_pkg.sv | 9 +
 rtl/instruction_queue.sv | 74 +++++++
 tb/tb_instruction_queue.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/instruction_queue_pkg.sv
// Shared definitions for the instruction queue.
//   INSN_W : width of one instruction word (bits)
package instruction_queue_pkg;

    localparam int unsigned INSN_W = 32;

    typedef logic [INSN_W-1:0] insn_t;

endpackage : instruction_queue_pkg

// File: rtl/instruction_queue.sv
// Instruction queue: a DEPTH-entry circular FIFO of 32-bit instruction words.
// Pushes come from the instruction memory response, and pops return data one cycle later.
//
// Ports:
//   clk        : sole clock, rising edge
//   rst        : synchronous reset, active-low
//   imem_rdata : instruction word to enqueue
//   imem_resp  : push strobe, imem_rdata valid this cycle
//   iq_pop     : dequeue request
//   iq_rdata   : dequeued word (registered, holds when iq_resp=0)
//   iq_resp    : one-cycle pulse following each accepted pop
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              imem_resp,
    input  logic              iq_pop,
    output logic [INSN_W-1:0] iq_rdata,
    output logic              iq_resp
);

    localparam logic [WIDTH:0] PtrOne = {{WIDTH{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit above the index bits. Because DEPTH is a power
    // of two, a plain +1 wraps the index from DEPTH-1 to 0 and toggles the wrap bit.
    logic [WIDTH:0]  head;
    logic [WIDTH:0]  tail;
    insn_t           mem [DEPTH];

    logic            empty;
    logic            full;
    logic            push_ok;
    logic            pop_ok;

    always_comb begin
        empty   = (head == tail);
        full    = (head[WIDTH-1:0] == tail[WIDTH-1:0]) && (head[WIDTH] != tail[WIDTH]);
        // Both are judged on the pre-edge state. There is no bypass when the queue is
        // empty, and a push is dropped when it is full, even if a pop is accepted too.
        push_ok = imem_resp && !full;
        pop_ok  = iq_pop && !empty;
    end

    // The storage array is not reset. The reset pointers make any stale contents unreachable.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[tail[WIDTH-1:0]] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            iq_resp  <= 1'b0;
            iq_rdata <= '0;
        end else begin
            iq_resp <= pop_ok;
            if (push_ok) begin
                tail <= tail + PtrOne;
            end
            if (pop_ok) begin
                head     <= head + PtrOne;
                iq_rdata <= mem[head[WIDTH-1:0]];
            end
        end
    end

endmodule : instruction_queue

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue. A queue-based reference model follows the
// FIFO rules, and every cycle's iq_resp/iq_rdata is compared with it.
module tb_instruction_queue;

    localparam int unsigned DEPTH = 32;

    logic        clk;
    logic        rst;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        iq_pop;
    logic [31:0] iq_rdata;
    logic        iq_resp;

    instruction_queue #(
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_rdata(imem_rdata),
        .imem_resp (imem_resp),
        .iq_pop    (iq_pop),
        .iq_rdata  (iq_rdata),
        .iq_resp   (iq_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [31:0] model[$];
    logic        m_resp;
    logic [31:0] m_rdata;

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, update the model at the edge, then check outputs on the falling edge.
    task automatic cycle(input string tag, input logic p, input logic [31:0] d,
                         input logic q, input logic r);
        bit push_ok;
        bit pop_ok;
        imem_resp  = p;
        imem_rdata = d;
        iq_pop     = q;
        rst        = r;
        @(posedge clk);
        if (!r) begin
            model.delete();
            m_resp  = 1'b0;
            m_rdata = '0;
        end else begin
            pop_ok  = q && (model.size() > 0);
            push_ok = p && (model.size() < DEPTH);
            m_resp  = pop_ok;
            if (pop_ok) m_rdata = model.pop_front();
            if (push_ok) model.push_back(d);
        end
        @(negedge clk);
        check({tag, ".resp"}, {31'd0, iq_resp}, {31'd0, m_resp});
        check({tag, ".rdata"}, iq_rdata, m_rdata);
    endtask

    task automatic push(input string tag, input logic [31:0] d);
        cycle(tag, 1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic pop(input string tag);
        cycle(tag, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        int pbias;
        int qbias;
        total      = 0;
        bad        = 0;
        m_resp     = 1'b0;
        m_rdata    = '0;
        rst        = 1'b0;
        imem_resp  = 1'b0;
        imem_rdata = '0;
        iq_pop     = 1'b0;

        // Reset state
        cycle("reset0", 1'b1, 32'h1234_5678, 1'b1, 1'b0);
        cycle("reset1", 1'b0, 32'h0, 1'b0, 1'b0);

        // Pop on empty queue
        pop("pop_empty");
        idle("pop_empty_after");

        // Single entry round trip
        push("single_push", 32'hAAAA_0001);
        idle("single_idle");
        pop("single_pop");
        idle("single_after");
        pop("single_empty");

        // Fill, overflow push dropped, drain, one extra pop
        for (int i = 0; i < DEPTH; i++) push("fill", 32'hA0B0_C0D0 + i);
        push("overflow", 32'hDEAD_BEEF);
        for (int i = 0; i <= DEPTH; i++) begin
            pop("drain");
            check("no_deadbeef", {31'd0, (iq_rdata === 32'hDEAD_BEEF) && iq_resp}, 32'd0);
        end

        // Pointers now sit on the wrap point; push and pop across it
        for (int i = 0; i < 20; i++) push("wrap_push_a", 32'h5000_0000 + i);
        for (int i = 0; i < 20; i++) pop("wrap_pop_a");
        for (int i = 0; i < 25; i++) push("wrap_push_b", 32'h6000_0000 + i);
        for (int i = 0; i < 25; i++) pop("wrap_pop_b");

        // Simultaneous push and pop at occupancy 1, and at full
        push("sim_seed", 32'h7000_0000);
        cycle("sim_both", 1'b1, 32'h7000_0001, 1'b1, 1'b1);
        cycle("sim_both2", 1'b1, 32'h7000_0002, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) push("sim_fill", 32'h7100_0000 + i);
        cycle("sim_full_both", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        // Push and pop on an empty queue: the pop must not see the new entry
        for (int i = 0; i < DEPTH; i++) pop("sim_drain");
        cycle("sim_empty_both", 1'b1, 32'h7200_0000, 1'b1, 1'b1);
        pop("sim_empty_after");

        // Reset with 5 entries queued
        for (int i = 0; i < 5; i++) push("rst_fill", 32'h8000_0000 + i);
        cycle("rst_mid", 1'b1, 32'h8000_00FF, 1'b1, 1'b0);
        pop("rst_pop_after");
        push("rst_push_after", 32'h8100_0000);
        pop("rst_pop_new");

        // Randomised traffic with phases biased toward filling and draining
        for (int ph = 0; ph < 12; ph++) begin
            pbias = (ph % 2 == 0) ? 85 : 30;
            qbias = (ph % 2 == 0) ? 30 : 85;
            for (int i = 0; i < 150; i++) begin
                cycle("rand", $urandom_range(0, 99) < pbias, $urandom,
                      $urandom_range(0, 99) < qbias, $urandom_range(0, 299) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instruction_queue
